// File: rtl/x2050_pkg.sv
// Shared definitions for the x2050rrq channel routine-request arbiter:
// FSM state encoding, channel indices and the fixed priority order.
package x2050_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GRANT = 3'd1,
    ST_FIRST = 3'd2,
    ST_RUN   = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

  localparam int NUM_CH = 4;

  localparam logic [1:0] CH0 = 2'd0;  // multiplexor channel
  localparam logic [1:0] CH1 = 2'd1;  // selector channels 1-3
  localparam logic [1:0] CH2 = 2'd2;
  localparam logic [1:0] CH3 = 2'd3;

  // Slot k lives at bits [2k +: 2]; slot 0 is the highest priority.
  localparam logic [7:0] PRIO_ORDER = {CH0, CH3, CH2, CH1};

endpackage

// File: rtl/x2050pri4.sv
// Combinational 4-input fixed-priority encoder: one-hot winner plus any-valid.
module x2050pri4
  import x2050_pkg::*;
(
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic       valid
);

  logic [1:0] idx_s;
  logic       found_s;

  // Walk the priority table from highest slot down; first set request wins.
  always_comb begin
    grant   = 4'b0000;
    idx_s   = 2'd0;
    found_s = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx_s = PRIO_ORDER[2*k +: 2];
      if (!found_s && req[idx_s]) begin
        grant[idx_s] = 1'b1;
        found_s      = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/x2050rrq.sv
// Channel routine-request arbiter: captures channel requests, grants one at a
// legal ROS break-in point, sequences the routine and enforces a CPU lockout.
module x2050rrq
  import x2050_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int LOCKOUT = 2
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_ros_advance,
  input  logic [3:0] i_req,
  input  logic [3:0] i_mask,
  input  logic       i_break_in_ok,
  input  logic       i_routine_done,
  output logic [3:0] o_routine_requesting,
  output logic       o_routine_recd,
  output logic       o_firstcycle,
  output logic       o_busy,
  output logic [3:0] o_pending,
  output logic       o_timeout
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int LW = (LOCKOUT > 0) ? $clog2(LOCKOUT + 1) : 1;
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT - 1);

  state_t          state_r;
  logic [TW-1:0]   timer_r;
  logic [LW-1:0]   lock_r;
  logic [3:0]      elig_s;
  logic [3:0]      win_s;
  logic            win_valid_s;
  logic [3:0]      clr_s;

  assign elig_s = o_pending & i_mask;

  x2050pri4 u_pri (
    .req   (elig_s),
    .grant (win_s),
    .valid (win_valid_s)
  );

  // Pending bit of the granted channel drops on the GRANT->FIRST edge.
  always_comb begin
    if (state_r == ST_GRANT && i_ros_advance) begin
      clr_s = o_routine_requesting;
    end else begin
      clr_s = 4'b0000;
    end
  end

  // Request capture, arbitration FSM and all registered outputs.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_r              <= ST_IDLE;
      timer_r              <= '0;
      lock_r               <= '0;
      o_pending            <= 4'b0000;
      o_routine_requesting <= 4'b0000;
      o_routine_recd       <= 1'b0;
      o_firstcycle         <= 1'b0;
      o_busy               <= 1'b0;
      o_timeout            <= 1'b0;
    end else begin
      o_pending <= (o_pending | i_req) & ~clr_s;
      o_timeout <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (win_valid_s && i_break_in_ok && i_ros_advance) begin
            state_r              <= ST_GRANT;
            o_routine_requesting <= win_s;
            o_routine_recd       <= 1'b1;
            o_busy               <= 1'b1;
            timer_r              <= '0;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          if (i_ros_advance) begin
            state_r        <= ST_FIRST;
            o_routine_recd <= 1'b0;
            o_firstcycle   <= 1'b1;
            timer_r        <= '0;
          end else if (timer_r == TIMER_MAX) begin
            // Abort: pending stays set so the channel is retried later.
            state_r              <= ST_IDLE;
            o_routine_recd       <= 1'b0;
            o_busy               <= 1'b0;
            o_routine_requesting <= 4'b0000;
            o_timeout            <= 1'b1;
            timer_r              <= '0;
          end else begin
            timer_r <= timer_r + TW'(1);
          end
        end
        ST_FIRST: begin
          if (i_ros_advance) begin
            state_r      <= ST_RUN;
            o_firstcycle <= 1'b0;
          end else begin
            state_r <= ST_FIRST;
          end
        end
        ST_RUN: begin
          if (i_routine_done && i_ros_advance) begin
            if (LOCKOUT == 0) begin
              state_r <= ST_IDLE;
              o_busy  <= 1'b0;
            end else begin
              state_r <= ST_HOLD;
              lock_r  <= LW'(LOCKOUT);
            end
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_HOLD: begin
          if (i_ros_advance) begin
            if (lock_r <= LW'(1)) begin
              state_r <= ST_IDLE;
              o_busy  <= 1'b0;
              lock_r  <= '0;
            end else begin
              lock_r <= lock_r - LW'(1);
            end
          end else begin
            state_r <= ST_HOLD;
          end
        end
        default: begin
          state_r              <= ST_IDLE;
          timer_r              <= '0;
          lock_r               <= '0;
          o_routine_requesting <= 4'b0000;
          o_routine_recd       <= 1'b0;
          o_firstcycle         <= 1'b0;
          o_busy               <= 1'b0;
        end
      endcase
    end
  end

endmodule
